alu_cmd_issuer: RTL and testbench

Initiator-side sequencer that drives the ALU operand/command port and collects its result. Accepts one operation at a time on a valid/ready request stream, presents it to the ALU with correct `INP_VALID`/`CE` signalling, optionally as split operand delivery (OPA first, OPB later), and waits the mode/command-dependent ALU latency. Captures `RES` and flags and returns them on a valid/ready response stream. Sits between the test/host command source and the ALU, owning the ALU input pins that the bench driver otherwise drives.

---
 rtl/alu_issue_pkg.sv | 31 +++
 rtl/alu_issue_wait_ctr.sv | 25 ++
 rtl/alu_cmd_issuer.sv | 175 +++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and helpers for the ALU command issuer.
// State encoding, captured flag layout and per-command ALU latency.
package alu_issue_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_A,
      GAP,
      ISSUE_B,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic err;
      logic oflow;
      logic cout;
      logic g;
      logic l;
      logic e;
   } flags_t;

   localparam logic [3:0] MUL_CMD_LO = 4'd9;
   localparam logic [3:0] MUL_CMD_HI = 4'd10;

   // Arithmetic multiplies need an extra cycle before RES is valid.
   function automatic logic [3:0] lat_of(input logic mode, input logic [3:0] cmd);
      return (mode && (cmd == MUL_CMD_LO || cmd == MUL_CMD_HI)) ? 4'd2 : 4'd1;
   endfunction

endpackage

// File: rtl/alu_issue_wait_ctr.sv
// Loadable 4-bit down-counter used to time both the operand gap and the ALU wait.
// done is high whenever the count has reached zero.
module alu_issue_wait_ctr (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic       done
);

   logic [3:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Sequences one ALU operation at a time from a request stream to a response stream.
// Define ALU_ISSUE_SPLIT_EN to build split operand delivery (ISSUE_A/GAP, req_split, req_gap).
module alu_cmd_issuer
   import alu_issue_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CMD_WIDTH  = 4
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_opa,
   input  logic [DATA_WIDTH-1:0] req_opb,
   input  logic [CMD_WIDTH-1:0]  req_cmd,
   input  logic                  req_mode,
   input  logic                  req_cin,
   input  logic                  req_split,
   input  logic [3:0]            req_gap,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH+1:0] rsp_res,
   output logic [5:0]            rsp_flags,
   output logic [DATA_WIDTH-1:0] OPA,
   output logic [DATA_WIDTH-1:0] OPB,
   output logic [CMD_WIDTH-1:0]  CMD,
   output logic                  MODE,
   output logic                  CIN,
   output logic                  CE,
   output logic [1:0]            INP_VALID,
   input  logic [DATA_WIDTH+1:0] RES,
   input  logic                  COUT,
   input  logic                  OFLOW,
   input  logic                  G,
   input  logic                  E,
   input  logic                  L,
   input  logic                  ERR
);

   state_t                state, state_nx;
   logic [DATA_WIDTH-1:0] opa_q, opb_q;
   logic [CMD_WIDTH-1:0]  cmd_q;
   logic                  mode_q, cin_q;
   logic                  live_q;
   logic [DATA_WIDTH+1:0] res_q;
   flags_t                flags_q;
   logic                  accept, capture;
   logic                  ctr_load, ctr_done;
   logic [3:0]            ctr_val;

`ifdef ALU_ISSUE_SPLIT_EN
   logic [3:0]            gap_q;
`else
   logic                  unused_split;
   assign unused_split = ^{req_split, req_gap};
`endif

   alu_issue_wait_ctr u_ctr (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .load     (ctr_load),
      .load_val (ctr_val),
      .done     (ctr_done)
   );

   // live_q keeps req_ready low until the first edge after reset release.
   assign req_ready = live_q && (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == RESP);
   assign rsp_res   = res_q;
   assign rsp_flags = flags_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         live_q  <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         cmd_q   <= '0;
         mode_q  <= 1'b0;
         cin_q   <= 1'b0;
         res_q   <= '0;
         flags_q <= '0;
`ifdef ALU_ISSUE_SPLIT_EN
         gap_q   <= '0;
`endif
      end else begin
         state  <= state_nx;
         live_q <= 1'b1;
         if (accept) begin
            opa_q  <= req_opa;
            opb_q  <= req_opb;
            cmd_q  <= req_cmd;
            mode_q <= req_mode;
            cin_q  <= req_cin;
`ifdef ALU_ISSUE_SPLIT_EN
            gap_q  <= req_gap;
`endif
         end
         if (capture) begin
            res_q   <= RES;
            flags_q <= {ERR, OFLOW, COUT, G, L, E};
         end
      end
   end

   always_comb begin
      state_nx  = state;
      ctr_load  = 1'b0;
      ctr_val   = '0;
      capture   = 1'b0;
      CE        = 1'b0;
      INP_VALID = 2'b00;
      OPA       = '0;
      OPB       = '0;
      CMD       = '0;
      MODE      = 1'b0;
      CIN       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef ALU_ISSUE_SPLIT_EN
               state_nx = req_split ? ISSUE_A : ISSUE_B;
`else
               state_nx = ISSUE_B;
`endif
            end
         end
`ifdef ALU_ISSUE_SPLIT_EN
         ISSUE_A, GAP: begin
            CE        = 1'b1;
            INP_VALID = 2'b01;
            OPA       = opa_q;
            CMD       = cmd_q;
            MODE      = mode_q;
            CIN       = cin_q;
            if (state == ISSUE_A) begin
               // Counter loaded with gap-1 so GAP lasts exactly gap_q cycles.
               if (gap_q != '0) begin
                  ctr_load = 1'b1;
                  ctr_val  = gap_q - 4'd1;
                  state_nx = GAP;
               end else begin
                  state_nx = ISSUE_B;
               end
            end else if (ctr_done) begin
               state_nx = ISSUE_B;
            end
         end
`endif
         ISSUE_B, WAIT: begin
            CE        = 1'b1;
            INP_VALID = 2'b11;
            OPA       = opa_q;
            OPB       = opb_q;
            CMD       = cmd_q;
            MODE      = mode_q;
            CIN       = cin_q;
            if (state == ISSUE_B) begin
               ctr_load = 1'b1;
               ctr_val  = lat_of(mode_q, 4'(cmd_q)) - 4'd1;
               state_nx = WAIT;
            end else if (ctr_done) begin
               capture  = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a small registered ALU stand-in.
// Expected results are hand-computed constants; the ALU model only supplies RES/flags.
module tb_alu_cmd_issuer;

   logic       CLK;
   logic       RESET_N;
   logic       req_valid, req_ready;
   logic [7:0] req_opa, req_opb;
   logic [3:0] req_cmd;
   logic       req_mode, req_cin, req_split;
   logic [3:0] req_gap;
   logic       rsp_valid, rsp_ready;
   logic [9:0] rsp_res;
   logic [5:0] rsp_flags;
   logic [7:0] OPA, OPB;
   logic [3:0] CMD;
   logic       MODE, CIN, CE;
   logic [1:0] INP_VALID;
   logic [9:0] RES;
   logic       COUT, OFLOW, G, E, L, ERR;

   int n_cmp = 0;
   int n_bad = 0;

   alu_cmd_issuer #(.DATA_WIDTH(8), .CMD_WIDTH(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
      .req_mode(req_mode), .req_cin(req_cin),
      .req_split(req_split), .req_gap(req_gap),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_res(rsp_res), .rsp_flags(rsp_flags),
      .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN),
      .CE(CE), .INP_VALID(INP_VALID),
      .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ALU stand-in: {ERR,OFLOW,COUT,G,L,E, RES[9:0]}; multiplies take one extra stage.
   function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] c, input logic m);
      logic [8:0] s;
      logic [9:0] r;
      logic [5:0] f;
      r = '0;
      f = '0;
      s = {1'b0, a} + {1'b0, b};
      if (m && c == 4'd0) begin
         r = {1'b0, s};
         f = {2'b00, s[8], 3'b000};
      end else if (m && c == 4'd9) begin
         r = 10'(({2'b00, a} + 10'd1) * ({2'b00, b} + 10'd1));
      end else if (m && c == 4'd10) begin
         r = 10'(({2'b00, a} << 1) * {2'b00, b});
      end else if (m && c == 4'd15) begin
         f = 6'b100000;
      end else if (!m && c == 4'd0) begin
         r = {2'b00, a & b};
      end
      return {f, r};
   endfunction

   logic [15:0] q1, q2, alu_out;
   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         q1 <= '0;
         q2 <= '0;
      end else begin
         q1 <= (CE && INP_VALID == 2'b11) ? alu_f(OPA, OPB, CMD, MODE) : '0;
         q2 <= q1;
      end
   end
   assign alu_out = (MODE && (CMD == 4'd9 || CMD == 4'd10)) ? q2 : q1;
   assign RES = alu_out[9:0];
   assign {ERR, OFLOW, COUT, G, L, E} = alu_out[15:10];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Presents one request and lets the accept edge pass.
   task automatic send(input logic m, input logic [3:0] c, input logic [7:0] a,
                       input logic [7:0] b, input logic s, input logic [3:0] g);
      req_valid = 1'b1;
      req_mode  = m;
      req_cmd   = c;
      req_opa   = a;
      req_opb   = b;
      req_cin   = 1'b0;
      req_split = s;
      req_gap   = g;
      chk("req_ready_before_accept", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      req_split = 1'b0;
      req_gap   = '0;
   endtask

   task automatic wait_rsp(input int exp_n, input string tag);
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_n));
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_valid_after_handshake", 32'(rsp_valid), 32'd0);
      chk("req_ready_after_handshake", 32'(req_ready), 32'd1);
   endtask

   initial begin
      RESET_N   = 1'b0;
      req_valid = 1'b0;
      req_opa   = '0;
      req_opb   = '0;
      req_cmd   = '0;
      req_mode  = 1'b0;
      req_cin   = 1'b0;
      req_split = 1'b0;
      req_gap   = '0;
      rsp_ready = 1'b0;

      // Reset values
      tick();
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_res", 32'(rsp_res), 32'd0);
      chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
      chk("rst_ce", 32'(CE), 32'd0);
      chk("rst_inp_valid", 32'(INP_VALID), 32'd0);
      chk("rst_opa", 32'(OPA), 32'd0);
      RESET_N = 1'b1;
      #1;
      chk("release_req_ready_pre_edge", 32'(req_ready), 32'd0);
      tick();
      chk("release_req_ready", 32'(req_ready), 32'd1);

      // ADD 0F + 01
      send(1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 4'd0);
      chk("add_ce_issue", 32'(CE), 32'd1);
      chk("add_inp_valid_issue", 32'(INP_VALID), 32'd3);
      chk("add_req_ready_busy", 32'(req_ready), 32'd0);
      wait_rsp(2, "add");
      chk("add_res", 32'(rsp_res), 32'h010);
      chk("add_flags", 32'(rsp_flags), 32'd0);
      chk("add_resp_ce", 32'(CE), 32'd0);
      finish_rsp();
      tick();

      // AND F0 & 3C
      send(1'b0, 4'd0, 8'hF0, 8'h3C, 1'b0, 4'd0);
      wait_rsp(2, "and");
      chk("and_res", 32'(rsp_res), 32'h030);
      finish_rsp();

      // Multiply: (3+1)*(4+1) = 20
      send(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 4'd0);
      chk("mul_inp_valid_issue", 32'(INP_VALID), 32'd3);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("mul_wait_ce", 32'(CE), 32'd1);
         chk("mul_wait_opa", 32'(OPA), 32'd3);
         chk("mul_wait_opb", 32'(OPB), 32'd4);
         chk("mul_wait_cmd", 32'(CMD), 32'd9);
         chk("mul_wait_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      tick();
      chk("mul_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("mul_res", 32'(rsp_res), 32'd20);
      chk("mul_resp_inp_valid", 32'(INP_VALID), 32'd0);
      finish_rsp();

      // Split ADD 05 + 06, gap 3
`ifdef ALU_ISSUE_SPLIT_EN
      send(1'b1, 4'd0, 8'h05, 8'h06, 1'b1, 4'd3);
      chk("split_a_opa", 32'(OPA), 32'h05);
      chk("split_a_opb", 32'(OPB), 32'h00);
      for (int i = 0; i < 4; i++) begin
         if (i != 0) tick();
         chk("split_a_inp_valid", 32'(INP_VALID), 32'd1);
         chk("split_a_ce", 32'(CE), 32'd1);
      end
      tick();
      chk("split_b_inp_valid", 32'(INP_VALID), 32'd3);
      chk("split_b_opb", 32'(OPB), 32'h06);
      wait_rsp(2, "split_tail");
`else
      send(1'b1, 4'd0, 8'h05, 8'h06, 1'b1, 4'd3);
      chk("nosplit_inp_valid", 32'(INP_VALID), 32'd3);
      wait_rsp(2, "nosplit");
`endif
      chk("split_res", 32'(rsp_res), 32'h00B);
      chk("split_err", 32'(rsp_flags[5]), 32'd0);
      finish_rsp();

      // Carry out: FF + 01
      send(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 4'd0);
      wait_rsp(2, "carry");
      chk("carry_res", 32'(rsp_res), 32'h100);
      chk("carry_flags", 32'(rsp_flags), 32'b001000);
      finish_rsp();

      // ALU error flag returned unchanged
      send(1'b1, 4'd15, 8'h12, 8'h34, 1'b0, 4'd0);
      wait_rsp(2, "err");
      chk("err_flags", 32'(rsp_flags), 32'b100000);
      finish_rsp();

      // Backpressure: 01 + 02 held for 5 cycles while a new request waits
      send(1'b1, 4'd0, 8'h01, 8'h02, 1'b0, 4'd0);
      wait_rsp(2, "bp");
      req_valid = 1'b1;
      req_mode  = 1'b0;
      req_cmd   = 4'd0;
      req_opa   = 8'hAA;
      req_opb   = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_res", 32'(rsp_res), 32'h003);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("bp_rsp_valid_done", 32'(rsp_valid), 32'd0);
      chk("bp_req_ready_idle", 32'(req_ready), 32'd1);
      chk("bp_no_early_issue", 32'(CE), 32'd0);
      tick();
      req_valid = 1'b0;
      chk("bp_second_opa", 32'(OPA), 32'hAA);
      chk("bp_second_inp_valid", 32'(INP_VALID), 32'd3);
      wait_rsp(2, "bp_second");
      chk("bp_second_res", 32'(rsp_res), 32'h00A);
      finish_rsp();

      // Reset in the middle of WAIT of an ADD
      send(1'b1, 4'd0, 8'h20, 8'h22, 1'b0, 4'd0);
      tick();
      chk("midrst_wait_ce", 32'(CE), 32'd1);
      RESET_N = 1'b0;
      #1;
      chk("midrst_ce", 32'(CE), 32'd0);
      chk("midrst_inp_valid", 32'(INP_VALID), 32'd0);
      chk("midrst_opa", 32'(OPA), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      tick();
      tick();
      RESET_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
         chk("midrst_idle_ce", 32'(CE), 32'd0);
         chk("midrst_idle_inp_valid", 32'(INP_VALID), 32'd0);
         chk("midrst_idle_req_ready", 32'(req_ready), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
